idle_deletion_ctrl: RTL and testbench



---
 rtl/idle_deletion_ctrl.sv | 126 ++++++++++++
 tb/tb_idle_deletion_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/idle_deletion_ctrl.sv
// Sequencing controller for the 100GbE PCS transmit idle-deletion FIFO.
// Removes N_AM idle blocks per AM period and reserves N_AM read slots for AM insertion.
module idle_deletion_ctrl #(
    parameter int NB_ADDR   = 5,
    parameter int AM_PERIOD = 16384,
    parameter int N_AM      = 20,
    parameter int NB_CREDIT = 8,
    parameter int NB_BCNT   = 14
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_enable,
    input  logic                 i_valid,
    input  logic                 i_is_idle,
    input  logic                 i_fifo_empty,
    output logic                 o_write_enb,
    output logic                 o_read_enb,
    output logic                 o_am_insert,
    output logic [NB_CREDIT-1:0] o_credit,
    output logic [NB_ADDR-1:0]   o_occupancy,
    output logic                 o_overflow_err,
    output logic                 o_underflow_err
);

    localparam int NB_SUM = NB_CREDIT + 1;

    localparam logic [NB_BCNT-1:0] BCNT_LAST  = NB_BCNT'(AM_PERIOD - 1);
    localparam logic [31:0]        N_AM_U     = N_AM;
    localparam logic [NB_SUM-1:0]  N_AM_SUM   = NB_SUM'(N_AM);
    localparam logic [NB_SUM-1:0]  CREDIT_MAX = {1'b0, {NB_CREDIT{1'b1}}};
    localparam logic [NB_ADDR-1:0] OCC_FULL   = {NB_ADDR{1'b1}};

    logic [NB_BCNT-1:0]   bcnt_q,   bcnt_d;
    logic [NB_CREDIT-1:0] credit_q, credit_d;
    logic [NB_ADDR-1:0]   occ_q,    occ_d;
    logic                 ovf_q,    ovf_d;
    logic                 unf_q,    unf_d;

    logic              act;
    logic              am_slot;
    logic              add_credit;
    logic              del;
    logic              full;
    logic              write_en;
    logic              read_en;
    logic              drop;
    logic              miss;
    logic [31:0]       bcnt_ext;
    logic [NB_SUM-1:0] credit_sum;

    // Gating with the reset keeps the FIFO enables quiet while reset is held.
    assign act        = i_valid & i_enable & ~i_reset;
    assign bcnt_ext   = 32'(bcnt_q);
    assign am_slot    = (bcnt_ext < N_AM_U);
    assign add_credit = act & (bcnt_q == '0);
    assign del        = act & i_is_idle & (credit_q != '0);
    assign full       = (occ_q == OCC_FULL);

    assign write_en = act & ~del & ~full;
    assign read_en  = act & ~am_slot & (occ_q != '0) & ~i_fifo_empty;
    assign drop     = act & ~del & full;
    assign miss     = act & ~am_slot & ~read_en;

    assign o_write_enb     = write_en;
    assign o_read_enb      = read_en;
    assign o_am_insert     = act & am_slot;
    assign o_credit        = credit_q;
    assign o_occupancy     = occ_q;
    assign o_overflow_err  = ovf_q;
    assign o_underflow_err = unf_q;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        bcnt_d   = bcnt_q;
        credit_d = credit_q;
        occ_d    = occ_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;

        // One extra bit of headroom lets the add-then-saturate be done without wrap.
        credit_sum = {1'b0, credit_q};
        if (add_credit) begin
            credit_sum = credit_sum + N_AM_SUM;
        end
        if (del) begin
            credit_sum = credit_sum - NB_SUM'(1);
        end

        if (!i_enable) begin
            bcnt_d   = '0;
            credit_d = '0;
            occ_d    = '0;
            ovf_d    = 1'b0;
            unf_d    = 1'b0;
        end else if (act) begin
            bcnt_d   = (bcnt_q == BCNT_LAST) ? '0 : bcnt_q + NB_BCNT'(1);
            credit_d = (credit_sum > CREDIT_MAX) ? CREDIT_MAX[NB_CREDIT-1:0]
                                                 : credit_sum[NB_CREDIT-1:0];
            case ({write_en, read_en})
                2'b10:   occ_d = occ_q + NB_ADDR'(1);
                2'b01:   occ_d = occ_q - NB_ADDR'(1);
                default: occ_d = occ_q;
            endcase
            ovf_d = ovf_q | drop;
            unf_d = unf_q | miss;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            bcnt_q   <= '0;
            credit_q <= '0;
            occ_q    <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            bcnt_q   <= bcnt_d;
            credit_q <= credit_d;
            occ_q    <= occ_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

endmodule

// File: tb/tb_idle_deletion_ctrl.sv
// Directed bench for idle_deletion_ctrl: a small-period instance plus an
// always-AM instance used to exercise FIFO overflow.
module tb_idle_deletion_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic       a_enable, a_valid, a_idle, a_empty, a_hold_empty;
    logic       a_wr, a_rd, a_am, a_ovf, a_unf;
    logic [3:0] a_credit;
    logic [2:0] a_occ;
    logic [2:0] a_fifo_cnt;

    logic       b_enable, b_valid, b_idle, b_empty;
    logic       b_wr, b_rd, b_am, b_ovf, b_unf;
    logic [5:0] b_credit;
    logic [2:0] b_occ;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    idle_deletion_ctrl #(
        .NB_ADDR(3), .AM_PERIOD(16), .N_AM(2), .NB_CREDIT(4), .NB_BCNT(4)
    ) u_dut (
        .i_clock(clk), .i_reset(rst), .i_enable(a_enable), .i_valid(a_valid),
        .i_is_idle(a_idle), .i_fifo_empty(a_empty),
        .o_write_enb(a_wr), .o_read_enb(a_rd), .o_am_insert(a_am),
        .o_credit(a_credit), .o_occupancy(a_occ),
        .o_overflow_err(a_ovf), .o_underflow_err(a_unf)
    );

    idle_deletion_ctrl #(
        .NB_ADDR(3), .AM_PERIOD(16), .N_AM(16), .NB_CREDIT(6), .NB_BCNT(4)
    ) u_dut_ovf (
        .i_clock(clk), .i_reset(rst), .i_enable(b_enable), .i_valid(b_valid),
        .i_is_idle(b_idle), .i_fifo_empty(b_empty),
        .o_write_enb(b_wr), .o_read_enb(b_rd), .o_am_insert(b_am),
        .o_credit(b_credit), .o_occupancy(b_occ),
        .o_overflow_err(b_ovf), .o_underflow_err(b_unf)
    );

    // Environment model of the FIFO fill level, driving the empty flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_fifo_cnt <= '0;
        end else if (!a_enable) begin
            a_fifo_cnt <= '0;
        end else if (a_wr && !a_rd) begin
            a_fifo_cnt <= a_fifo_cnt + 3'd1;
        end else if (a_rd && !a_wr) begin
            a_fifo_cnt <= a_fifo_cnt - 3'd1;
        end
    end
    assign a_empty = (a_fifo_cnt == 3'd0) || a_hold_empty;

    task automatic drive_a(input logic v, input logic idle);
        a_valid = v;
        a_idle  = idle;
        @(negedge clk);
    endtask

    task automatic drive_b(input logic v, input logic idle);
        b_valid = v;
        b_idle  = idle;
        @(negedge clk);
    endtask

    task automatic next_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        a_valid = 1'b0;
        b_valid = 1'b0;
        a_hold_empty = 1'b0;
        rst = 1'b1;
        #2;
        next_edge();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        a_enable = 1'b1; a_valid = 1'b1; a_idle = 1'b1;
        b_enable = 1'b1; b_valid = 1'b1; b_idle = 1'b0;
        #1 rst = 1'b1;
        #2;
        n_checks++; if ({a_wr, a_rd, a_am} !== 3'b000) begin n_fail++; $display("FAIL rst_enables_a: got %b exp 000", {a_wr, a_rd, a_am}); end
        n_checks++; if ({b_wr, b_rd, b_am} !== 3'b000) begin n_fail++; $display("FAIL rst_enables_b: got %b exp 000", {b_wr, b_rd, b_am}); end
        n_checks++; if (a_credit !== 4'd0) begin n_fail++; $display("FAIL rst_credit: got %0d exp 0", a_credit); end
        n_checks++; if (a_occ !== 3'd0) begin n_fail++; $display("FAIL rst_occ: got %0d exp 0", a_occ); end
        n_checks++; if ({a_ovf, a_unf, b_ovf, b_unf} !== 4'b0000) begin n_fail++; $display("FAIL rst_flags: got %b exp 0000", {a_ovf, a_unf, b_ovf, b_unf}); end
        next_edge();
        rst = 1'b0;
        a_valid = 1'b0;
        b_valid = 1'b0;
    endtask

    task automatic test_stream();
        do_reset();
        for (int b = 0; b < 16; b++) begin
            logic e_am, e_rd;
            logic [2:0] e_occ;
            e_am  = (b < 2);
            e_rd  = (b >= 2);
            e_occ = (b == 0) ? 3'd1 : 3'd2;
            drive_a(1'b1, 1'b0);
            n_checks++; if (a_am !== e_am) begin n_fail++; $display("FAIL s1_am blk%0d: got %b exp %b", b, a_am, e_am); end
            n_checks++; if ({a_wr, a_rd} !== {1'b1, e_rd}) begin n_fail++; $display("FAIL s1_wr_rd blk%0d: got %b exp %b", b, {a_wr, a_rd}, {1'b1, e_rd}); end
            next_edge();
            n_checks++; if (a_credit !== 4'd2) begin n_fail++; $display("FAIL s1_credit blk%0d: got %0d exp 2", b, a_credit); end
            n_checks++; if (a_occ !== e_occ) begin n_fail++; $display("FAIL s1_occ blk%0d: got %0d exp %0d", b, a_occ, e_occ); end
            n_checks++; if ({a_ovf, a_unf} !== 2'b00) begin n_fail++; $display("FAIL s1_flags blk%0d: got %b exp 00", b, {a_ovf, a_unf}); end
        end
        a_valid = 1'b0;
    endtask

    // Blocks 3 and 4 are deleted; block 5 finds no credit, is written into an
    // empty FIFO, and its slot has nothing to read.
    task automatic test_idle_delete();
        do_reset();
        for (int b = 0; b < 16; b++) begin
            logic e_wr, e_rd, e_unf;
            logic [3:0] e_cr;
            logic [2:0] e_occ;
            e_wr  = !(b == 3 || b == 4);
            e_rd  = (b >= 2 && b != 5);
            e_unf = (b >= 5);
            e_cr  = (b < 3) ? 4'd2 : (b == 3) ? 4'd1 : 4'd0;
            case (b)
                0:       e_occ = 3'd1;
                1, 2:    e_occ = 3'd2;
                3:       e_occ = 3'd1;
                4:       e_occ = 3'd0;
                default: e_occ = 3'd1;
            endcase
            drive_a(1'b1, (b >= 3 && b <= 5));
            n_checks++; if ({a_wr, a_rd} !== {e_wr, e_rd}) begin n_fail++; $display("FAIL s2_wr_rd blk%0d: got %b exp %b", b, {a_wr, a_rd}, {e_wr, e_rd}); end
            next_edge();
            n_checks++; if (a_credit !== e_cr) begin n_fail++; $display("FAIL s2_credit blk%0d: got %0d exp %0d", b, a_credit, e_cr); end
            n_checks++; if (a_occ !== e_occ) begin n_fail++; $display("FAIL s2_occ blk%0d: got %0d exp %0d", b, a_occ, e_occ); end
            n_checks++; if (a_unf !== e_unf) begin n_fail++; $display("FAIL s2_unf blk%0d: got %b exp %b", b, a_unf, e_unf); end
        end
        a_valid = 1'b0;
    endtask

    task automatic test_wrap_delete();
        do_reset();
        for (int b = 0; b < 16; b++) begin
            drive_a(1'b1, (b == 3));
            next_edge();
        end
        n_checks++; if (a_credit !== 4'd1) begin n_fail++; $display("FAIL s3_pre_credit: got %0d exp 1", a_credit); end
        n_checks++; if (a_occ !== 3'd1) begin n_fail++; $display("FAIL s3_pre_occ: got %0d exp 1", a_occ); end
        drive_a(1'b1, 1'b1);
        n_checks++; if ({a_am, a_wr, a_rd} !== 3'b100) begin n_fail++; $display("FAIL s3_wrap_enables: got %b exp 100", {a_am, a_wr, a_rd}); end
        next_edge();
        n_checks++; if (a_credit !== 4'd2) begin n_fail++; $display("FAIL s3_wrap_credit: got %0d exp 2", a_credit); end
        n_checks++; if (a_occ !== 3'd1) begin n_fail++; $display("FAIL s3_wrap_occ: got %0d exp 1", a_occ); end
        a_valid = 1'b0;
    endtask

    task automatic test_overflow();
        do_reset();
        for (int k = 0; k < 8; k++) begin
            logic e_wr;
            logic [2:0] e_occ;
            e_wr  = (k < 7);
            e_occ = (k < 7) ? 3'(k + 1) : 3'd7;
            drive_b(1'b1, 1'b0);
            n_checks++; if ({b_am, b_wr, b_rd} !== {1'b1, e_wr, 1'b0}) begin n_fail++; $display("FAIL s4_enables k%0d: got %b exp %b", k, {b_am, b_wr, b_rd}, {1'b1, e_wr, 1'b0}); end
            next_edge();
            n_checks++; if (b_occ !== e_occ) begin n_fail++; $display("FAIL s4_occ k%0d: got %0d exp %0d", k, b_occ, e_occ); end
            n_checks++; if (b_ovf !== (k == 7)) begin n_fail++; $display("FAIL s4_ovf k%0d: got %b exp %b", k, b_ovf, (k == 7)); end
        end
        n_checks++; if (b_credit !== 6'd16) begin n_fail++; $display("FAIL s4_credit: got %0d exp 16", b_credit); end
        for (int k = 0; k < 3; k++) begin
            drive_b(1'b0, 1'b0);
            next_edge();
            n_checks++; if (b_ovf !== 1'b1) begin n_fail++; $display("FAIL s4_ovf_sticky k%0d: got %b exp 1", k, b_ovf); end
        end
        b_enable = 1'b0;
        drive_b(1'b1, 1'b0);
        n_checks++; if ({b_am, b_wr, b_rd} !== 3'b000) begin n_fail++; $display("FAIL s4_dis_enables: got %b exp 000", {b_am, b_wr, b_rd}); end
        next_edge();
        n_checks++; if ({b_ovf, b_occ, b_credit} !== 10'd0) begin n_fail++; $display("FAIL s4_dis_clear: got ovf %b occ %0d cr %0d exp 0 0 0", b_ovf, b_occ, b_credit); end
        b_enable = 1'b1;
        b_valid = 1'b0;
    endtask

    task automatic test_valid_toggle();
        logic [2:0] e_occ;
        do_reset();
        e_occ = 3'd0;
        for (int c = 0; c < 32; c++) begin
            logic v;
            int vi;
            v  = (c % 2 == 0);
            vi = c / 2;
            drive_a(v, 1'b0);
            if (v) begin
                n_checks++; if ({a_am, a_wr, a_rd} !== {(vi < 2), 1'b1, (vi >= 2)}) begin n_fail++; $display("FAIL s5_valid_en c%0d: got %b exp %b", c, {a_am, a_wr, a_rd}, {(vi < 2), 1'b1, (vi >= 2)}); end
                if (vi < 2) e_occ = e_occ + 3'd1;
            end else begin
                n_checks++; if ({a_am, a_wr, a_rd} !== 3'b000) begin n_fail++; $display("FAIL s5_idle_en c%0d: got %b exp 000", c, {a_am, a_wr, a_rd}); end
            end
            next_edge();
            n_checks++; if (a_credit !== 4'd2) begin n_fail++; $display("FAIL s5_credit c%0d: got %0d exp 2", c, a_credit); end
            n_checks++; if (a_occ !== e_occ) begin n_fail++; $display("FAIL s5_occ c%0d: got %0d exp %0d", c, a_occ, e_occ); end
        end
        drive_a(1'b1, 1'b0);
        n_checks++; if ({a_am, a_rd} !== 2'b10) begin n_fail++; $display("FAIL s5_wrap_am: got %b exp 10", {a_am, a_rd}); end
        next_edge();
        n_checks++; if (a_credit !== 4'd4) begin n_fail++; $display("FAIL s5_wrap_credit: got %0d exp 4", a_credit); end
        a_valid = 1'b0;
    endtask

    task automatic test_mid_reset();
        do_reset();
        drive_a(1'b1, 1'b0); next_edge();
        drive_a(1'b1, 1'b0); next_edge();
        a_hold_empty = 1'b1;
        drive_a(1'b1, 1'b1); next_edge();
        drive_a(1'b1, 1'b0); next_edge();
        n_checks++; if ({a_occ, a_credit} !== {3'd3, 4'd1}) begin n_fail++; $display("FAIL s6_pre: got occ %0d cr %0d exp 3 1", a_occ, a_credit); end
        a_valid = 1'b1;
        a_idle  = 1'b0;
        #2 rst = 1'b1;
        #1;
        n_checks++; if ({a_occ, a_credit, a_ovf, a_unf} !== 9'd0) begin n_fail++; $display("FAIL s6_async_clear: got occ %0d cr %0d ovf %b unf %b exp all 0", a_occ, a_credit, a_ovf, a_unf); end
        n_checks++; if ({a_am, a_wr, a_rd} !== 3'b000) begin n_fail++; $display("FAIL s6_rst_enables: got %b exp 000", {a_am, a_wr, a_rd}); end
        next_edge();
        rst = 1'b0;
        a_hold_empty = 1'b0;
        drive_a(1'b1, 1'b0);
        n_checks++; if (a_am !== 1'b1) begin n_fail++; $display("FAIL s6_post_rst_am: got %b exp 1", a_am); end
        next_edge();
        n_checks++; if ({a_occ, a_credit} !== {3'd1, 4'd2}) begin n_fail++; $display("FAIL s6_post_rst_state: got occ %0d cr %0d exp 1 2", a_occ, a_credit); end
        drive_a(1'b1, 1'b0); next_edge();
        a_hold_empty = 1'b1;
        drive_a(1'b1, 1'b0); next_edge();
        n_checks++; if ({a_occ, a_unf} !== {3'd3, 1'b1}) begin n_fail++; $display("FAIL s6_pre_dis: got occ %0d unf %b exp 3 1", a_occ, a_unf); end
        a_enable = 1'b0;
        drive_a(1'b1, 1'b0);
        n_checks++; if ({a_am, a_wr, a_rd} !== 3'b000) begin n_fail++; $display("FAIL s6_dis_enables: got %b exp 000", {a_am, a_wr, a_rd}); end
        next_edge();
        n_checks++; if ({a_occ, a_credit, a_unf} !== 8'd0) begin n_fail++; $display("FAIL s6_dis_clear: got occ %0d cr %0d unf %b exp 0 0 0", a_occ, a_credit, a_unf); end
        a_enable = 1'b1;
        a_hold_empty = 1'b0;
        drive_a(1'b1, 1'b0);
        n_checks++; if (a_am !== 1'b1) begin n_fail++; $display("FAIL s6_post_dis_am: got %b exp 1", a_am); end
        next_edge();
        a_valid = 1'b0;
    endtask

    initial begin
        a_enable = 1'b1; a_valid = 1'b0; a_idle = 1'b0; a_hold_empty = 1'b0;
        b_enable = 1'b1; b_valid = 1'b0; b_idle = 1'b0; b_empty = 1'b0;
        test_reset();
        test_stream();
        test_idle_delete();
        test_wrap_delete();
        test_overflow();
        test_valid_toggle();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
